// File: rtl/cpu_pkg.sv
// Shared types and constants for the program-counter slice.
package cpu_pkg;

    localparam int PC_W = 16;
    localparam logic [PC_W-1:0] RESET_PC_DEF = 16'h0000;

    // Direction in which the high byte must move after a relative low-byte add
    typedef enum logic [1:0] {
        NONE,
        UP,
        DOWN
    } fix_dir_t;

    // Relative-branch sequencing
    typedef enum logic {
        IDLE,
        FIX
    } pc_state_t;

    // Byte to add to pch for a given fix-up direction (0, +1 or -1)
    function automatic logic [7:0] dir_adjust(input fix_dir_t d);
        logic [7:0] adj;
        adj = 8'h00;
        case (d)
            UP:      adj = 8'h01;
            DOWN:    adj = 8'hFF;
            default: adj = 8'h00;
        endcase
        return adj;
    endfunction

endpackage

// File: rtl/pc_byte_adder.sv
// 8-bit adder of a byte and a two's-complement offset; reports the carry and
// whether the byte above must be bumped up, down or left alone.
module pc_byte_adder
    import cpu_pkg::*;
(
    input  logic [7:0] base,
    input  logic [7:0] offset,
    output logic [7:0] sum,
    output logic       carry,
    output fix_dir_t   dir
);

    // Unsigned add; the direction combines carry-out with the offset sign
    always_comb begin
        {carry, sum} = {1'b0, base} + {1'b0, offset};
        dir = NONE;
        if (carry && !offset[7]) begin
            dir = UP;
        end else if (!carry && offset[7]) begin
            dir = DOWN;
        end
    end

endmodule

// File: rtl/program_counter.sv
// 16-bit 6502 program counter with byte-wise bus load/drive, increment and
// relative branch. Define PC_BRANCH_FIXUP_EN for the two-cycle branch with a
// separate high-byte fix-up cycle (busy/page_x live); otherwise the branch
// completes in one cycle and busy/page_x are tied low.
module program_counter
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
)
(
    input  logic        clk,
    input  logic        clr_n,
    input  logic [7:0]  datain,
    output logic [7:0]  dataout,
    input  logic        wl,
    input  logic        wh,
    input  logic        inc,
    input  logic        rel,
    input  logic        ol,
    input  logic        oh,
    output logic [15:0] addr,
    output logic        busy,
    output logic        page_x
);

    logic [7:0] pcl;
    logic [7:0] pch;

    logic [7:0] lo_sum;
    logic       lo_carry;
    fix_dir_t   lo_dir;
    logic [7:0] hi_adj;
    logic [7:0] hi_sum;
    logic       hi_carry;
    fix_dir_t   hi_dir;
    logic       fix_busy;
    logic       unused_bits;

    // Low-byte branch add: pcl + offset
    pc_byte_adder u_lo_add (
        .base   (pcl),
        .offset (datain),
        .sum    (lo_sum),
        .carry  (lo_carry),
        .dir    (lo_dir)
    );

    // High-byte adjust: pch + {0, +1, -1}, wrapping within 8 bits
    pc_byte_adder u_hi_add (
        .base   (pch),
        .offset (hi_adj),
        .sum    (hi_sum),
        .carry  (hi_carry),
        .dir    (hi_dir)
    );

    assign unused_bits = ^{lo_carry, hi_carry, hi_dir};

`ifdef PC_BRANCH_FIXUP_EN
    localparam bit FIXUP_EN = 1'b1;

    pc_state_t state;
    pc_state_t state_nxt;
    fix_dir_t  fix_q;

    // FSM state register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Only a branch needing a high-byte fix-up leaves IDLE; FIX lasts one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!wl && !wh && rel && (lo_dir != NONE)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Remember the fix-up direction while idle; consumed in FIX
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            fix_q <= NONE;
        end else if (state == IDLE) begin
            fix_q <= lo_dir;
        end
    end

    assign hi_adj   = dir_adjust(fix_q);
    assign fix_busy = (state == FIX);
`else
    localparam bit FIXUP_EN = 1'b0;

    // Same-cycle adjust makes the low add plus high adjust a full 16-bit add
    assign hi_adj   = dir_adjust(lo_dir);
    assign fix_busy = 1'b0;
`endif

    assign busy   = fix_busy;
    assign page_x = fix_busy;

    // PC register: fix-up, then load, then branch, then increment
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            {pch, pcl} <= RESET_PC;
        end else if (fix_busy) begin
            pch <= hi_sum;
        end else if (wl || wh) begin
            if (wl) pcl <= datain;
            if (wh) pch <= datain;
        end else if (rel) begin
            pcl <= lo_sum;
            if (!FIXUP_EN) pch <= hi_sum;
        end else if (inc) begin
            {pch, pcl} <= {pch, pcl} + 16'd1;
        end
    end

    assign addr    = {pch, pcl};
    assign dataout = ol ? pcl : (oh ? pch : 8'hzz);

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed literal checks followed
// by randomized commands compared each cycle against a target-address model.
module tb_program_counter;

`ifdef PC_BRANCH_FIXUP_EN
    localparam bit TB_FIX = 1'b1;
`else
    localparam bit TB_FIX = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr_n = 1'b1;
    logic [7:0]  datain = 8'h00;
    wire  [7:0]  dataout;
    logic        wl = 1'b0, wh = 1'b0, inc = 1'b0, rel = 1'b0, ol = 1'b0, oh = 1'b0;
    logic [15:0] addr;
    logic        busy, page_x;

    int n_checks = 0;
    int n_fail   = 0;
    bit run_cmp  = 1'b0;

    always #5 clk = ~clk;

    program_counter #(.RESET_PC(16'h1234)) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .datain  (datain),
        .dataout (dataout),
        .wl      (wl),
        .wh      (wh),
        .inc     (inc),
        .rel     (rel),
        .ol      (ol),
        .oh      (oh),
        .addr    (addr),
        .busy    (busy),
        .page_x  (page_x)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a branch targets pc + sign-extended offset. With the
    // fix-up enabled and the target on another page, the low byte lands first
    // and the target's high byte one cycle later.
    logic [15:0] m_pc = 16'h1234;
    bit          m_pend = 1'b0;
    logic [7:0]  m_hi = 8'h00;
    logic [15:0] tgt;

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_pc   = 16'h1234;
            m_pend = 1'b0;
        end else if (m_pend) begin
            m_pc[15:8] = m_hi;
            m_pend     = 1'b0;
        end else if (wl || wh) begin
            if (wl) m_pc[7:0]  = datain;
            if (wh) m_pc[15:8] = datain;
        end else if (rel) begin
            tgt = m_pc + {{8{datain[7]}}, datain};
            if (TB_FIX && (tgt[15:8] != m_pc[15:8])) begin
                m_pc[7:0] = tgt[7:0];
                m_hi      = tgt[15:8];
                m_pend    = 1'b1;
            end else begin
                m_pc = tgt;
            end
        end else if (inc) begin
            m_pc = m_pc + 16'd1;
        end
    end

    // Per-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        if (run_cmp && clr_n) begin
            chk("addr", addr, m_pc);
            chk("busy", {15'd0, busy}, {15'd0, m_pend});
            chk("page_x", {15'd0, page_x}, {15'd0, m_pend});
            if (ol || oh)
                chk("dataout", {8'd0, dataout}, {8'd0, (ol ? m_pc[7:0] : m_pc[15:8])});
        end
    end

    task automatic cyc(input logic wl_i, input logic wh_i, input logic inc_i,
                       input logic rel_i, input logic [7:0] d);
        wl = wl_i; wh = wh_i; inc = inc_i; rel = rel_i; datain = d;
        @(negedge clk);
        #1;
        wl = 1'b0; wh = 1'b0; inc = 1'b0; rel = 1'b0;
    endtask

    task automatic lit(input string name, input logic [15:0] exp);
        chk(name, addr, exp);
        chk({name, "_model"}, m_pc, exp);
    endtask

    task automatic load(input logic [15:0] v);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, v[15:8]);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, v[7:0]);
    endtask

    task automatic reset_pulse();
        clr_n = 1'b0;
        #1;
        chk("reset_addr", addr, 16'h1234);
        chk("reset_busy", {15'd0, busy}, 16'd0);
        #1;
        clr_n = 1'b1;
    endtask

    initial begin
        logic [31:0] r;
        @(negedge clk);
        #1;
        reset_pulse();
        run_cmp = 1'b1;

        // load and drive
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'hFE);
        lit("wl_load", 16'h12FE);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
        lit("wh_load", 16'hFFFE);
        ol = 1'b1; #1;
        chk("ol_drive", {8'd0, dataout}, 16'h00FE);
        ol = 1'b0; oh = 1'b1; #1;
        chk("oh_drive", {8'd0, dataout}, 16'h00FF);
        ol = 1'b1; #1;
        chk("ol_priority", {8'd0, dataout}, 16'h00FE);
        ol = 1'b0; oh = 1'b0;

        // increment wrap and carry
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        lit("inc_ffff", 16'hFFFF);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        lit("inc_wrap", 16'h0000);
        load(16'h12FF);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        lit("inc_carry", 16'h1300);

        // load beats inc
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h34);
        lit("wl_over_inc", 16'h1334);

        // forward page cross, inc during FIX
        load(16'h10F0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h20);
        lit("fwd_c1", TB_FIX ? 16'h1010 : 16'h1110);
        chk("fwd_busy", {15'd0, busy}, {15'd0, TB_FIX});
        chk("fwd_pagex", {15'd0, page_x}, {15'd0, TB_FIX});
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        lit("fwd_c2", TB_FIX ? 16'h1110 : 16'h1111);
        chk("fwd_busy_done", {15'd0, busy}, 16'd0);

        // backward page cross
        load(16'h1005);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'hF0);
        lit("bwd_c1", TB_FIX ? 16'h10F5 : 16'h0FF5);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        lit("bwd_c2", 16'h0FF5);

        // backward, same page
        load(16'h1080);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'hF0);
        lit("bwd_nocross", 16'h1070);
        chk("nocross_busy", {15'd0, busy}, 16'd0);

        // reset during FIX aborts the fix-up
        load(16'h10F0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h20);
        reset_pulse();
        chk("abort_model_idle", {15'd0, m_pend}, 16'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h05);
        lit("post_abort_rel", 16'h1239);
        chk("post_abort_busy", {15'd0, busy}, 16'd0);

        // randomized commands
        for (int i = 0; i < 800; i++) begin
            r = $urandom;
            wl  = (r[2:0] == 3'd0);
            wh  = (r[5:3] == 3'd0);
            inc = r[6];
            rel = (r[9:7] < 3'd3);
            ol  = r[10];
            oh  = r[11];
            datain = 8'($urandom);
            @(negedge clk);
            #1;
            if ($urandom_range(0, 60) == 0) reset_pulse();
        end

        run_cmp = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- 16-bit 6502 program counter.
- Sits between the internal 8-bit data bus and the address-bus driver.
- Loads low and high bytes separately from the bus, where the general-purpose registers also drive operands.
- Drives each byte back onto the bus for JSR/BRK pushes.
- Provides increment and signed relative-branch arithmetic for instruction fetch.

Parameters:
- RESET_PC, 16'h0000: value the counter takes on reset.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- clr_n  input  1  asynchronous active-low reset.
- datain  input  8  byte from the internal data bus.
- dataout  output  8  byte to the internal data bus; 8'hzz when not enabled.
- wl  input  1  write enable, low byte (pcl <= datain).
- wh  input  1  write enable, high byte (pch <= datain).
- inc  input  1  increment the 16-bit PC by 1.
- rel  input  1  add sign-extended datain to the PC (branch taken).
- ol  input  1  output enable, low byte.
- oh  input  1  output enable, high byte.
- addr  output  16  current PC {pch,pcl}, always driven.
- busy  output  1  high during the relative-branch fix-up cycle.
- page_x  output  1  one-cycle pulse: the relative branch crossed a page.

Behaviour:
- Reset:
  - clr_n low asynchronously forces {pch,pcl}=RESET_PC, busy=0, page_x=0, and clears the fix-up state.
  - Reset asserted mid-branch aborts the fix-up; no partial high-byte update survives.
- dataout:
  - Combinational.
  - ol=1 gives pcl.
  - ol=0 and oh=1 gives pch.
  - Otherwise 8'hzz.
  - ol has priority if both are asserted.
- addr: combinational {pch,pcl}; no latency.
- Command priority per edge when busy=0, highest first:
  1. wl/wh. Either or both load datain into the selected byte(s); inc and rel are ignored that cycle.
  2. rel
  3. inc
  4. hold
- Increment:
  - 16-bit, wraps 16'hFFFF to 16'h0000.
  - Carry from pcl into pch happens in the same cycle.
- Relative branch:
  - Offset is datain, two's complement, -128..+127.
  - Cycle 1 (state IDLE):
    - pcl <= pcl + datain (8-bit).
    - Compute fix-up direction: up if the unsigned low add carries and the offset is positive; down if it does not carry and the offset is negative; otherwise none.
    - If no fix-up is needed, stay in IDLE and page_x stays 0.
    - Otherwise go to FIX, with busy=1 during FIX.
  - Cycle 2 (state FIX):
    - pch <= pch ± 1, with 8-bit wrap (FF+1=00, 00-1=FF).
    - page_x=1 for this cycle.
    - Return to IDLE.
  - During FIX, wl/wh/inc/rel are ignored; ol/oh still drive dataout, which shows the intermediate value.
- State machine: IDLE, FIX. Only rel with a needed fix-up leaves IDLE; FIX always returns to IDLE after one cycle.

Optional Feature:
- Macro PC_BRANCH_FIXUP_EN.
- Defined:
  - Two-cycle relative branch as above.
  - busy and page_x are live, matching 6502 branch page-cross timing.
- Undefined:
  - rel performs a full 16-bit add of the sign-extended offset in one cycle.
  - No FIX state; busy and page_x are tied 0.
  - Final PC value is identical to the defined case.

Decomposition:
- Shared package, cpu_pkg:
  - Fix-up direction enum: NONE, UP, DOWN.
  - FSM state typedef: IDLE, FIX.
  - Constant PC_W=16.
  - RESET_PC default constant.
- One natural sub-module: pc_byte_adder, an 8-bit adder returning sum, carry, and fix-up direction from byte and signed offset. It is reused for the cycle-1 low add and the cycle-2 high adjust.

Test Plan:
- Reset: RESET_PC=16'h1234; pulse clr_n low between edges -> addr=16'h1234 immediately, dataout=8'hzz, busy=0.
- Load and drive:
  - wl with datain=8'hFE, then wh with datain=8'hFF -> addr=16'hFFFE.
  - ol=1 gives dataout=8'hFE; oh=1 gives 8'hFF; both asserted gives 8'hFE.
- Increment wrap:
  - From 16'hFFFE, inc for two edges -> FFFF, then 0000.
  - From 16'h12FF, inc -> 16'h1300 in one cycle.
- Forward page cross:
  - PC=16'h10F0, rel with datain=8'h20 -> after edge 1 addr=16'h1010 and busy=1; after edge 2 addr=16'h1110 with page_x=1 during FIX.
  - Undefined-macro build gives 16'h1110 after one edge.
- Backward page cross and no-cross:
  - PC=16'h1005, datain=8'hF0 -> 16'h10F5, then 16'h0FF5.
  - PC=16'h1080, datain=8'hF0 -> 16'h1070 in one cycle, busy stays 0.
- Simultaneity and abort:
  - wl+inc in the same cycle -> load only.
  - inc asserted during FIX is ignored.
  - clr_n low during FIX -> addr=RESET_PC, busy=0, and the next rel starts from IDLE.
